// File: rtl/speech_sequencer.sv
// Phoneme sequencer: CPU-fed byte FIFO that drives a phoneme player one code at a time,
// handshaking on the player's busy line and giving up if busy never rises.
module speech_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        address,
    input  logic        speech_write_H,
    input  logic        speech_read_H,
    input  logic [15:0] datain,
    output logic [15:0] dataout,
    input  logic        phoneme_speech_busy,
    output logic [7:0]  phoneme_sel,
    output logic        start_phoneme_output
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PULSE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [TW-1:0]  tcnt;
    logic           overflow;
    logic           timeout;

    logic           push_req;
    logic           ctrl_wr;
    logic           flush;
    logic           clear_flags;
    logic           full;
    logic           empty;
    logic           do_push;
    logic           do_pop;
    logic [15:0]    status;
    logic           unused_ok;

    assign push_req    = speech_write_H && !address;
    assign ctrl_wr     = speech_write_H && address;
    assign flush       = ctrl_wr && datain[0];
    assign clear_flags = ctrl_wr && (datain[0] || datain[1]);
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign do_push     = push_req && !full && !reset;
    assign do_pop      = (state == LOAD);
    assign unused_ok   = ^datain[15:8];

    assign status  = {3'b000, phoneme_speech_busy, (state != IDLE), timeout,
                      overflow, full, empty, 7'(count)};
    assign dataout = speech_read_H ? status : 16'bz;

    // Storage has no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= datain[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            tcnt                 <= '0;
            overflow             <= 1'b0;
            timeout              <= 1'b0;
            phoneme_sel          <= 8'h00;
            start_phoneme_output <= 1'b0;
        end else if (flush) begin
            // Flush abandons the sequence outright; phoneme_sel keeps its last code.
            state                <= IDLE;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            tcnt                 <= '0;
            overflow             <= 1'b0;
            timeout              <= 1'b0;
            start_phoneme_output <= 1'b0;
        end else begin
            start_phoneme_output <= 1'b0;

            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);

            if (push_req && full)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty && !phoneme_speech_busy)
                        state <= LOAD;
                end
                LOAD: begin
                    phoneme_sel <= mem[rd_ptr];
                    state       <= PULSE;
                end
                PULSE: begin
                    start_phoneme_output <= 1'b1;
                    tcnt                 <= '0;
                    state                <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (phoneme_speech_busy) begin
                        state <= WAIT_DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!phoneme_speech_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (clear_flags) begin
                overflow <= 1'b0;
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed bench for speech_sequencer: a behavioural phoneme player plus a scoreboard of
// expected phoneme codes that is checked at every start pulse.
module tb_speech_sequencer;

    logic        clk;
    logic        reset;
    logic        address;
    logic        speech_write_H;
    logic        speech_read_H;
    logic [15:0] datain;
    logic [15:0] dataout;
    logic        phoneme_speech_busy;
    logic [7:0]  phoneme_sel;
    logic        start_phoneme_output;

    int          total;
    int          bad;
    int          pulse_cnt;
    int          mode;
    int          dly;
    int          run;
    logic        prev_start;
    logic [7:0]  exp_q[$];

    speech_sequencer #(.DEPTH(16), .TIMEOUT(255)) dut (
        .clk                  (clk),
        .reset                (reset),
        .address              (address),
        .speech_write_H       (speech_write_H),
        .speech_read_H        (speech_read_H),
        .datain               (datain),
        .dataout              (dataout),
        .phoneme_speech_busy  (phoneme_speech_busy),
        .phoneme_sel          (phoneme_sel),
        .start_phoneme_output (start_phoneme_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: holds the write strobe across exactly one rising edge.
    task automatic applyStimulus(input logic addr, input logic [15:0] data);
        address        = addr;
        datain         = data;
        speech_write_H = 1'b1;
        @(posedge clk);
        #1;
        speech_write_H = 1'b0;
    endtask

    task automatic pushPhoneme(input logic [7:0] code, input bit expect_play);
        if (expect_play)
            exp_q.push_back(code);
        applyStimulus(1'b0, {8'h00, code});
    endtask

    task automatic readStatus(output logic [15:0] s);
        speech_read_H = 1'b1;
        #1;
        s = dataout;
        speech_read_H = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        logic [15:0] s;
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            readStatus(s);
            if (s[11] == 1'b0 && s[6:0] == 7'd0)
                done = 1'b1;
        end
        checkOutput(tag, {15'b0, done}, 16'h0001);
    endtask

    // Player model: mode 0 raises busy two cycles after a start for 10 cycles,
    // mode 1 holds busy high, mode 2 ties busy low.
    initial begin
        phoneme_speech_busy = 1'b0;
        dly = 0;
        run = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1) begin
                phoneme_speech_busy = 1'b1;
                dly = 0;
                run = 0;
            end else if (mode == 2) begin
                phoneme_speech_busy = 1'b0;
                dly = 0;
                run = 0;
            end else if (start_phoneme_output) begin
                dly = 2;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    phoneme_speech_busy = 1'b1;
                    run = 10;
                end
            end else if (run > 0) begin
                run--;
                if (run == 0)
                    phoneme_speech_busy = 1'b0;
            end else begin
                phoneme_speech_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (start_phoneme_output) begin
            pulse_cnt++;
            checkOutput("start_not_double", {15'b0, prev_start}, 16'h0000);
            checkOutput("busy_low_at_start", {15'b0, phoneme_speech_busy}, 16'h0000);
            checkOutput("start_expected", {15'b0, (exp_q.size() != 0)}, 16'h0001);
            if (exp_q.size() != 0)
                checkOutput("phoneme_order", {8'h00, phoneme_sel}, {8'h00, exp_q.pop_front()});
        end
        prev_start = start_phoneme_output;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] s;
        bit          hit;
        total = 0;
        bad = 0;
        pulse_cnt = 0;
        mode = 0;
        prev_start = 1'b0;
        reset = 1'b1;
        address = 1'b0;
        speech_write_H = 1'b0;
        speech_read_H = 1'b0;
        datain = 16'h0000;

        tick(3);
        reset = 1'b0;
        tick(1);
        readStatus(s);
        checkOutput("reset_status", s, 16'h0080);
        checkOutput("reset_sel", {8'h00, phoneme_sel}, 16'h0000);
        checkOutput("reset_start", {15'b0, start_phoneme_output}, 16'h0000);

        // Single phoneme with exact start latency
        pushPhoneme(8'h17, 1'b1);
        tick(1);
        checkOutput("lat_k1_start", {15'b0, start_phoneme_output}, 16'h0000);
        tick(1);
        checkOutput("lat_k2_sel", {8'h00, phoneme_sel}, 16'h0017);
        checkOutput("lat_k2_start", {15'b0, start_phoneme_output}, 16'h0000);
        tick(1);
        checkOutput("lat_k3_start", {15'b0, start_phoneme_output}, 16'h0001);
        waitIdle("single_idle", 100);
        readStatus(s);
        checkOutput("single_status", s, 16'h0080);
        checkOutput("single_pulses", 16'(pulse_cnt), 16'd1);

        // Sentence of three back-to-back pushes
        pushPhoneme(8'h01, 1'b1);
        pushPhoneme(8'h02, 1'b1);
        pushPhoneme(8'h03, 1'b1);
        waitIdle("sentence_idle", 300);
        checkOutput("sentence_pulses", 16'(pulse_cnt), 16'd4);
        checkOutput("sentence_drained", 16'(exp_q.size()), 16'd0);

        // Timeout with busy tied low
        mode = 2;
        tick(1);
        pushPhoneme(8'h05, 1'b1);
        waitIdle("timeout_idle", 400);
        readStatus(s);
        checkOutput("timeout_status", s, 16'h0480);
        tick(20);
        checkOutput("timeout_pulses", 16'(pulse_cnt), 16'd5);
        applyStimulus(1'b1, 16'h0002);
        readStatus(s);
        checkOutput("timeout_cleared", s, 16'h0080);

        // Overflow with the player held busy, then drain through pointer wrap
        mode = 1;
        tick(1);
        for (int i = 0; i < 17; i++)
            pushPhoneme(8'h20 + 8'(i), (i < 16));
        readStatus(s);
        checkOutput("overflow_status", s, 16'h1310);
        applyStimulus(1'b1, 16'h0002);
        readStatus(s);
        checkOutput("overflow_cleared", s, 16'h1110);
        mode = 0;
        waitIdle("drain_idle", 1500);
        checkOutput("drain_pulses", 16'(pulse_cnt), 16'd21);
        checkOutput("drain_empty_q", 16'(exp_q.size()), 16'd0);

        // Flush during WAIT_DONE of the first phoneme
        pushPhoneme(8'h01, 1'b1);
        pushPhoneme(8'h02, 1'b1);
        pushPhoneme(8'h03, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick(1);
            if (phoneme_speech_busy && pulse_cnt == 22)
                hit = 1'b1;
        end
        checkOutput("flush_reached_wait_done", {15'b0, hit}, 16'h0001);
        exp_q.delete();
        applyStimulus(1'b1, 16'h0001);
        readStatus(s);
        checkOutput("flush_status", s, 16'h1080);
        tick(40);
        checkOutput("flush_pulses", 16'(pulse_cnt), 16'd22);
        checkOutput("flush_sel_hold", {8'h00, phoneme_sel}, 16'h0001);

        // Push and pop in the same cycle at count=4, then reset in PULSE
        mode = 1;
        tick(1);
        for (int i = 0; i < 4; i++)
            pushPhoneme(8'hA0 + 8'(i), 1'b1);
        readStatus(s);
        checkOutput("pp_count4", s, 16'h1004);
        mode = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(1);
            readStatus(s);
            if (s[11])
                hit = 1'b1;
        end
        checkOutput("pp_reached_load", {15'b0, hit}, 16'h0001);
        pushPhoneme(8'hA4, 1'b1);
        readStatus(s);
        checkOutput("pp_count_stays", s, 16'h0804);
        reset = 1'b1;
        address = 1'b0;
        datain = 16'h0055;
        speech_write_H = 1'b1;
        tick(1);
        reset = 1'b0;
        speech_write_H = 1'b0;
        exp_q.delete();
        checkOutput("rst_pulse_start", {15'b0, start_phoneme_output}, 16'h0000);
        checkOutput("rst_pulse_sel", {8'h00, phoneme_sel}, 16'h0000);
        readStatus(s);
        checkOutput("rst_pulse_status", s, 16'h0080);
        tick(20);
        checkOutput("rst_no_pulses", 16'(pulse_cnt), 16'd22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
